// File: rtl/aes_req_scheduler.sv
// aes_req_scheduler: single-outstanding AES request front-end with fault retry and timeout (AES_SCHED_STATS_EN adds stat counters)
module aes_req_scheduler #(
    parameter int TAG_W     = 8,
    parameter int MAX_RETRY = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_key,
    input  logic [127:0]     in_pt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             aes_start,
    output logic [127:0]     aes_key,
    output logic [127:0]     aes_pt,
    input  logic             aes_busy,
    input  logic             aes_done,
    input  logic [127:0]     aes_ct,
    input  logic             aes_fault,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_ct,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [3:0]       out_tries
`ifdef AES_SCHED_STATS_EN
    ,
    output logic [31:0]      stat_req,
    output logic [31:0]      stat_fault,
    output logic [31:0]      stat_err
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
    localparam logic [3:0]  MR = 4'(MAX_RETRY);
    localparam logic [15:0] TL = 16'(TIMEOUT - 1);
    state_t      state;
    logic [3:0]  tries;
    logic [15:0] timer;
    logic        unused_busy;
    assign unused_busy = aes_busy;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            aes_start <= 1'b0;
            aes_key   <= '0;
            aes_pt    <= '0;
            out_valid <= 1'b0;
            out_ct    <= '0;
            out_tag   <= '0;
            out_err   <= 1'b0;
            out_tries <= '0;
            tries     <= '0;
            timer     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        aes_key   <= in_key;
                        aes_pt    <= in_pt;
                        out_tag   <= in_tag;
                        tries     <= '0;
                        in_ready  <= 1'b0;
                        aes_start <= 1'b1;
                        state     <= ISSUE;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    aes_start <= 1'b0;
                    tries     <= tries + 4'd1;
                    timer     <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (aes_done && !aes_fault) begin
                        out_ct    <= aes_ct;
                        out_err   <= 1'b0;
                        out_tries <= tries;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (aes_done && tries <= MR) begin
                        aes_start <= 1'b1;
                        state     <= ISSUE;
                    end else if (aes_done || timer == TL) begin
                        // faulted ciphertext never reaches out_ct
                        out_ct    <= '0;
                        out_err   <= 1'b1;
                        out_tries <= tries;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef AES_SCHED_STATS_EN
    logic deliver;
    assign deliver = (state == HOLD) && out_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_req   <= '0;
            stat_fault <= '0;
            stat_err   <= '0;
        end else begin
            if (deliver && !(&stat_req))
                stat_req <= stat_req + 32'd1;
            if (deliver && out_err && !(&stat_err))
                stat_err <= stat_err + 32'd1;
            if (state == WAIT && aes_done && aes_fault && !(&stat_fault))
                stat_fault <= stat_fault + 32'd1;
        end
    end
`endif
endmodule
